// File: rtl/led_pwm_pkg.sv
// ----------------------------------------------------------------------------
// Package: led_pwm_pkg
// Shared definitions for the LED breathing controller and its PWM channels.
// Contents:
//   MODE_SEQ / MODE_ALL / MODE_STATIC / MODE_OFF  2-bit operating modes
//   ramp_state_e                                  triangle ramp direction
//   is_ramp_mode()                                true for modes driven by the ramp
// ----------------------------------------------------------------------------
package led_pwm_pkg;

    // Operating modes as seen on the mode input.
    localparam logic [1:0] MODE_SEQ    = 2'd0;
    localparam logic [1:0] MODE_ALL    = 2'd1;
    localparam logic [1:0] MODE_STATIC = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;

    // Direction of the triangle brightness ramp.
    typedef enum logic {
        RAMP_RISE = 1'b0,
        RAMP_FALL = 1'b1
    } ramp_state_e;

    // Only SEQ and ALL advance the ramp; STATIC and OFF leave it parked.
    function automatic logic is_ramp_mode(input logic [1:0] m);
        return (m == MODE_SEQ) || (m == MODE_ALL);
    endfunction

endpackage

// File: rtl/led_breathe_ctrl_pwm_channel.sv
// ----------------------------------------------------------------------------
// Module: pwm_channel
// One registered PWM pin. The pin is lit while the shared counter is below
// the channel's effective brightness, and the output polarity is applied at
// the register so the pin itself never glitches.
// Ports:
//   clk_i        system clock
//   rst_i        synchronous active-high reset, drives the pin to its off level
//   enable_i     0 forces the pin to its off level on the next clock
//   cnt_i        shared PWM counter
//   eff_level_i  brightness for this channel (0 = dark, all ones = 2^BITS-1 of 2^BITS lit)
//   pwm_o        registered pin, polarity per ACTIVE_LOW
// ----------------------------------------------------------------------------
module pwm_channel
    import led_pwm_pkg::*;
#(
    parameter int BITS       = 8,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    input  logic [BITS-1:0] cnt_i,
    input  logic [BITS-1:0] eff_level_i,
    output logic            pwm_o
);

    // The pin level that means "LED dark" for this polarity.
    localparam logic OFF_LEVEL = ACTIVE_LOW;

    logic lit;
    logic pwm_q;

    // Compare the counter against the brightness; a level of zero can never
    // be exceeded so the channel stays dark.
    always_comb begin
        lit = (cnt_i < eff_level_i);
    end

    // Register the pin so the output changes exactly one clock after the
    // counter, with reset and disable both parking it at the off level.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwm_q <= OFF_LEVEL;
        end else if (!enable_i) begin
            pwm_q <= OFF_LEVEL;
        end else begin
            pwm_q <= lit ^ ACTIVE_LOW;
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/led_breathe_ctrl.sv
// ----------------------------------------------------------------------------
// Module: led_breathe_ctrl
// Multi-channel LED breathing controller. A shared PWM counter sets the
// period, a prescaled triangle ramp sets the brightness, and the mode picks
// how that brightness is spread across the channels.
// Ports:
//   clk_i           system clock
//   rst_i           synchronous active-high reset, highest priority
//   enable_i        0 holds every counter and forces all pins off
//   mode_i          0=SEQ (rotating channel), 1=ALL, 2=STATIC, 3=OFF
//   static_level_i  brightness used in STATIC mode
//   pwm_out_o       registered PWM pins, polarity per ACTIVE_LOW
//   ch_sel_o        channel currently ramping in SEQ mode
//   cycle_done_o    one-clock strobe when a full up/down ramp completes
// ----------------------------------------------------------------------------
module led_breathe_ctrl
    import led_pwm_pkg::*;
#(
    parameter int NUM_CH     = 3,
    parameter int PWM_BITS   = 8,
    parameter int PRESCALER  = 2,
    parameter bit ACTIVE_LOW = 1'b1,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic [1:0]          mode_i,
    input  logic [PWM_BITS-1:0] static_level_i,
    output logic [NUM_CH-1:0]   pwm_out_o,
    output logic [CH_W-1:0]     ch_sel_o,
    output logic                cycle_done_o
);

    // A prescaler of zero still needs a one-bit register; its terminal
    // count is then zero so every period end is a ramp step.
    localparam int                    PRESC_W    = (PRESCALER > 0) ? PRESCALER : 1;
    localparam logic [PRESC_W-1:0]    PRESC_LAST = PRESC_W'((1 << PRESCALER) - 1);
    localparam logic [PWM_BITS-1:0]   LEVEL_MAX  = {PWM_BITS{1'b1}};
    localparam logic [CH_W-1:0]       CH_LAST    = CH_W'(NUM_CH - 1);

    logic [PWM_BITS-1:0] cnt_q,    cnt_d;
    logic [PWM_BITS-1:0] level_q,  level_d;
    logic [PRESC_W-1:0]  presc_q,  presc_d;
    ramp_state_e         state_q,  state_d;
    logic [CH_W-1:0]     ch_sel_q, ch_sel_d;
    logic [1:0]          mode_q,   mode_d;
    logic [PWM_BITS-1:0] static_q, static_d;
    logic                done_q,   done_d;

    logic                period_end;
    logic [PWM_BITS-1:0] eff_level [NUM_CH];

    // Last clock of a PWM period. Everything that affects duty is only
    // allowed to move here, so a period is never cut short or stretched.
    assign period_end = enable_i && (cnt_q == LEVEL_MAX);

    // State register for the counter, prescaler, ramp FSM and mode logic.
    // The mode is captured from the input during reset so the first period
    // after reset does not look like a mode change.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            level_q  <= '0;
            presc_q  <= '0;
            state_q  <= RAMP_RISE;
            ch_sel_q <= '0;
            mode_q   <= mode_i;
            static_q <= '0;
            done_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            presc_q  <= presc_d;
            state_q  <= state_d;
            ch_sel_q <= ch_sel_d;
            mode_q   <= mode_d;
            static_q <= static_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic. The counter free-runs while enabled; the ramp only
    // moves on period ends. A mode change wins over a ramp step and restarts
    // the ramp from dark on the first channel without flagging completion.
    always_comb begin
        cnt_d    = cnt_q;
        level_d  = level_q;
        presc_d  = presc_q;
        state_d  = state_q;
        ch_sel_d = ch_sel_q;
        mode_d   = mode_q;
        static_d = static_q;
        done_d   = 1'b0;

        if (enable_i) begin
            cnt_d = cnt_q + PWM_BITS'(1);
        end

        if (period_end) begin
            mode_d   = mode_i;
            static_d = static_level_i;

            if (mode_i != mode_q) begin
                level_d  = '0;
                presc_d  = '0;
                state_d  = RAMP_RISE;
                ch_sel_d = '0;
            end else if (is_ramp_mode(mode_q)) begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    if (state_q == RAMP_RISE) begin
                        level_d = level_q + PWM_BITS'(1);
                        if (level_d == LEVEL_MAX) begin
                            state_d = RAMP_FALL;
                        end
                    end else begin
                        level_d = level_q - PWM_BITS'(1);
                        if (level_d == '0) begin
                            state_d = RAMP_RISE;
                            done_d  = 1'b1;
                            if (mode_q == MODE_SEQ) begin
                                ch_sel_d = (ch_sel_q == CH_LAST) ? '0 : ch_sel_q + CH_W'(1);
                            end
                        end
                    end
                end else begin
                    presc_d = presc_q + PRESC_W'(1);
                end
            end
        end
    end

    // Output decode: spread the brightness over the channels according to
    // the registered mode. Only registered values feed this, so duty is
    // stable for a whole period.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            eff_level[i] = '0;
            case (mode_q)
                MODE_SEQ:    eff_level[i] = (ch_sel_q == CH_W'(i)) ? level_q : '0;
                MODE_ALL:    eff_level[i] = level_q;
                MODE_STATIC: eff_level[i] = static_q;
                default:     eff_level[i] = '0;
            endcase
        end
    end

    // One registered pin per channel.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        pwm_channel #(
            .BITS       (PWM_BITS),
            .ACTIVE_LOW (ACTIVE_LOW)
        ) u_ch (
            .clk_i       (clk_i),
            .rst_i       (rst_i),
            .enable_i    (enable_i),
            .cnt_i       (cnt_q),
            .eff_level_i (eff_level[g]),
            .pwm_o       (pwm_out_o[g])
        );
    end

    assign ch_sel_o     = ch_sel_q;
    assign cycle_done_o = done_q;

endmodule

// File: tb/tb_led_breathe_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench: tb_led_breathe_ctrl
// Two controllers share one set of inputs: dut1 (PRESCALER=0, active-low
// pins) and dut2 (PRESCALER=1, active-high pins). A cycle model predicts both
// outputs each clock; directed phases cover SEQ, STATIC, ALL, mode change,
// enable hold and mid-ramp reset.
// ----------------------------------------------------------------------------
module tb_led_breathe_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] mode;
    logic [3:0] staticLevel;

    logic [2:0] pwm1, pwm2;
    logic [1:0] chSel1, chSel2;
    logic       done1, done2;

    int checkCount = 0;
    int passCount  = 0;

    led_breathe_ctrl #(
        .NUM_CH(3), .PWM_BITS(4), .PRESCALER(0), .ACTIVE_LOW(1'b1)
    ) dut1 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode),
        .static_level_i(staticLevel), .pwm_out_o(pwm1), .ch_sel_o(chSel1),
        .cycle_done_o(done1)
    );

    led_breathe_ctrl #(
        .NUM_CH(3), .PWM_BITS(4), .PRESCALER(1), .ACTIVE_LOW(1'b0)
    ) dut2 (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .mode_i(mode),
        .static_level_i(staticLevel), .pwm_out_o(pwm2), .ch_sel_o(chSel2),
        .cycle_done_o(done2)
    );

    always #5 clk = ~clk;

    // Single point for every comparison.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic e, input logic [1:0] m, input logic [3:0] s);
        rst         = r;
        enable      = e;
        mode        = m;
        staticLevel = s;
    endtask

    // Reference model state for both configurations, index 0 = dut1, 1 = dut2.
    int         cyc = 0;
    int         pLast  [2] = '{0, 1};
    bit         aLow   [2] = '{1'b1, 1'b0};
    int         mCnt   [2];
    int         mLevel [2];
    int         mPresc [2];
    int         mCh    [2];
    int         mMode  [2];
    int         mStatic[2];
    bit         mRise  [2];
    logic [2:0] mPwm   [2];
    bit         mDone  [2];
    bit         lit;
    logic [5:0] expQ1[$];
    logic [5:0] expQ2[$];

    function automatic int effLevel(int k, int c);
        case (mMode[k])
            0:       return (c == mCh[k]) ? mLevel[k] : 0;
            1:       return mLevel[k];
            2:       return mStatic[k];
            default: return 0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) cyc = 0;
        else     cyc++;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                mCnt[k] = 0; mLevel[k] = 0; mPresc[k] = 0; mRise[k] = 1'b1;
                mCh[k] = 0; mMode[k] = int'(mode); mStatic[k] = 0;
                mPwm[k] = aLow[k] ? 3'b111 : 3'b000;
                mDone[k] = 1'b0;
            end else begin
                for (int c = 0; c < 3; c++) begin
                    lit = enable && (mCnt[k] < effLevel(k, c));
                    mPwm[k][c] = lit ? ~aLow[k] : aLow[k];
                end
                mDone[k] = 1'b0;
                if (enable && mCnt[k] == 15) begin
                    if (int'(mode) != mMode[k]) begin
                        mLevel[k] = 0; mPresc[k] = 0; mRise[k] = 1'b1; mCh[k] = 0;
                    end else if (mMode[k] < 2) begin
                        if (mPresc[k] == pLast[k]) begin
                            mPresc[k] = 0;
                            if (mRise[k]) begin
                                mLevel[k]++;
                                if (mLevel[k] == 15) mRise[k] = 1'b0;
                            end else begin
                                mLevel[k]--;
                                if (mLevel[k] == 0) begin
                                    mRise[k] = 1'b1;
                                    mDone[k] = 1'b1;
                                    if (mMode[k] == 0) mCh[k] = (mCh[k] + 1) % 3;
                                end
                            end
                        end else begin
                            mPresc[k]++;
                        end
                    end
                    mMode[k]   = int'(mode);
                    mStatic[k] = int'(staticLevel);
                end
                if (enable) mCnt[k] = (mCnt[k] + 1) % 16;
            end
        end
        expQ1.push_back({mPwm[0], 2'(mCh[0]), mDone[0]});
        expQ2.push_back({mPwm[1], 2'(mCh[1]), mDone[1]});
    end

    always @(negedge clk) begin
        logic [5:0] e;
        if (expQ1.size() > 0) begin
            e = expQ1.pop_front();
            checkOutput("sb1", {26'd0, pwm1, chSel1, done1}, {26'd0, e});
        end
        if (expQ2.size() > 0) begin
            e = expQ2.pop_front();
            checkOutput("sb2", {26'd0, pwm2, chSel2, done2}, {26'd0, e});
        end
    end

    // Wait for a completion strobe on one controller, recording which dut1
    // channels were lit on the way.
    task automatic waitDone(input int which, input int budget, output int at, output logic [2:0] litMask);
        bit seen;
        seen    = 1'b0;
        at      = -1;
        litMask = 3'b000;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            litMask |= ~pwm1;
            if ((which == 1) ? done1 : done2) begin
                at   = cyc;
                seen = 1'b1;
                break;
            end
        end
        checkOutput("doneSeen", {31'd0, seen}, 32'd1);
    endtask

    // Count lit (low) clocks per dut1 channel over n clocks.
    task automatic countLow(input int n, output int l0, output int l1, output int l2,
                            output int nDone, output bit inPhase);
        l0 = 0; l1 = 0; l2 = 0; nDone = 0; inPhase = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (!pwm1[0]) l0++;
            if (!pwm1[1]) l1++;
            if (!pwm1[2]) l2++;
            if (done1) nDone++;
            if (pwm1 != 3'b000 && pwm1 != 3'b111) inPhase = 1'b0;
        end
    endtask

    task automatic waitUntilCycle(input int target);
        for (int n = 0; n < 5000 && cyc < target; n++) @(negedge clk);
        checkOutput("reachCycle", cyc, target);
    endtask

    initial begin
        int         t0, t1, l0, l1, l2, nd;
        bit         ph;
        logic [2:0] mask;

        applyStimulus(1'b1, 1'b1, 2'd0, 4'd0);
        @(negedge clk);

        // Reset state, then SEQ breathing.
        checkOutput("rstPwm1",  {29'd0, pwm1}, 32'h7);
        checkOutput("rstPwm2",  {29'd0, pwm2}, 32'h0);
        checkOutput("rstChSel", {30'd0, chSel1}, 32'd0);
        checkOutput("rstDone",  {31'd0, done1}, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 4'd0);
        countLow(16, l0, l1, l2, nd, ph);
        checkOutput("darkBeforeStep", l0 + l1 + l2, 0);
        waitDone(1, 600, t0, mask);
        checkOutput("firstDoneAt", t0, 480);
        checkOutput("chSelAfter1", {30'd0, chSel1}, 32'd1);
        checkOutput("onlyCh0Lit", {29'd0, mask}, 32'h1);
        waitDone(1, 600, t0, mask);
        checkOutput("secondDoneAt", t0, 960);
        checkOutput("chSelAfter2", {30'd0, chSel1}, 32'd2);
        checkOutput("onlyCh1Lit", {29'd0, mask}, 32'h2);
        waitDone(1, 600, t0, mask);
        checkOutput("thirdDoneAt", t0, 1440);
        checkOutput("chSelAfter3", {30'd0, chSel1}, 32'd0);

        // Enable held low for 100 clocks at level 7.
        applyStimulus(1'b1, 1'b1, 2'd0, 4'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'd0, 4'd0);
        waitUntilCycle(112);
        applyStimulus(1'b0, 1'b0, 2'd0, 4'd0);
        @(negedge clk);
        checkOutput("disPwm1", {29'd0, pwm1}, 32'h7);
        checkOutput("disPwm2", {29'd0, pwm2}, 32'h0);
        waitUntilCycle(212);
        checkOutput("disHeld", {29'd0, pwm1}, 32'h7);
        applyStimulus(1'b0, 1'b1, 2'd0, 4'd0);
        countLow(16, l0, l1, l2, nd, ph);
        checkOutput("resumeDuty", l0, 7);
        checkOutput("resumeOthers", l1 + l2, 0);
        waitDone(1, 600, t0, mask);
        checkOutput("shiftedDoneAt", t0, 580);

        // SEQ -> ALL while level is 9.
        applyStimulus(1'b1, 1'b1, 2'd0, 4'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'd0, 4'd0);
        waitUntilCycle(150);
        applyStimulus(1'b0, 1'b1, 2'd1, 4'd0);
        waitUntilCycle(160);
        countLow(16, l0, l1, l2, nd, ph);
        checkOutput("modeChgDark", l0 + l1 + l2, 0);
        checkOutput("modeChgNoDone", nd, 0);
        checkOutput("modeChgChSel", {30'd0, chSel1}, 32'd0);
        countLow(16, l0, l1, l2, nd, ph);
        checkOutput("modeChgLevel1", l0 + l1 + l2, 3);
        checkOutput("modeChgPhase", {31'd0, ph}, 32'd1);

        // STATIC brightness.
        applyStimulus(1'b0, 1'b1, 2'd2, 4'd4);
        repeat (40) @(negedge clk);
        countLow(32, l0, l1, l2, nd, ph);
        checkOutput("static4Ch0", l0, 8);
        checkOutput("static4Ch1", l1, 8);
        checkOutput("static4Ch2", l2, 8);
        checkOutput("static4Phase", {31'd0, ph}, 32'd1);
        applyStimulus(1'b0, 1'b1, 2'd2, 4'd0);
        repeat (40) @(negedge clk);
        countLow(32, l0, l1, l2, nd, ph);
        checkOutput("static0", l0 + l1 + l2, 0);
        applyStimulus(1'b0, 1'b1, 2'd2, 4'd15);
        repeat (40) @(negedge clk);
        countLow(32, l0, l1, l2, nd, ph);
        checkOutput("static15", l0, 30);
        checkOutput("static15Phase", {31'd0, ph}, 32'd1);

        // ALL mode completion periods for both prescalers.
        applyStimulus(1'b0, 1'b1, 2'd1, 4'd15);
        waitDone(2, 3000, t0, mask);
        waitDone(2, 1100, t1, mask);
        checkOutput("allPeriodP1", t1 - t0, 960);
        waitDone(1, 600, t0, mask);
        waitDone(1, 600, t1, mask);
        checkOutput("allPeriodP0", t1 - t0, 480);
        countLow(32, l0, l1, l2, nd, ph);
        checkOutput("allPhase", {31'd0, ph}, 32'd1);

        // Reset pulse mid-fall on channel 2.
        applyStimulus(1'b1, 1'b1, 2'd0, 4'd0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b1, 2'd0, 4'd0);
        waitUntilCycle(1280);
        checkOutput("preRstChSel", {30'd0, chSel1}, 32'd2);
        applyStimulus(1'b1, 1'b1, 2'd0, 4'd0);
        @(negedge clk);
        checkOutput("midRstPwm1",  {29'd0, pwm1}, 32'h7);
        checkOutput("midRstPwm2",  {29'd0, pwm2}, 32'h0);
        checkOutput("midRstChSel", {30'd0, chSel1}, 32'd0);
        checkOutput("midRstDone",  {31'd0, done1}, 32'd0);
        applyStimulus(1'b0, 1'b1, 2'd0, 4'd0);
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
